// File: rtl/jstk2_led_frame.sv
// PmodJSTK2 frame engine: sends one "set LED RGB" packet (0x84, R, G, B, 0x00)
// over SPI mode 0, MSB first, and decodes the 5 joystick reply bytes captured
// during the same transfer into X/Y position and button state.
//
// SCLK timing is measured from the pin's point of view: SS_SETUP is the
// distance from ss_n falling to the first SCLK rise, so the SETUP state
// itself is shortened by the first bit's low half. Likewise FRAME_GAP is the
// time ss_n stays high before busy drops, so HOLD plus REST add up to it.
module jstk2_led_frame #(
    parameter int CLK_DIV   = 6,
    parameter int SS_SETUP  = 180,
    parameter int BYTE_GAP  = 120,
    parameter int FRAME_GAP = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] rgb_color,
    output logic        busy,
    output logic        done,
    output logic        ss_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic [9:0]  joy_x,
    output logic [9:0]  joy_y,
    output logic [1:0]  joy_btn
);

    // Largest value any phase counter must hold.
    localparam int MAX_AB  = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int MAX_CD  = (FRAME_GAP > CLK_DIV) ? FRAME_GAP : CLK_DIV;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counters run down to zero, so a phase of N cycles loads N-1.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SS_SETUP - CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(BYTE_GAP - 1);
    localparam logic [CNT_W-1:0] REST_LOAD  = CNT_W'(FRAME_GAP - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [7:0] CMD_BYTE = 8'h84;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_TAIL,
        ST_HOLD,
        ST_REST
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              half_reg, half_next;      // 0: sclk low half, 1: high half
    logic [2:0]        bit_reg, bit_next;
    logic [2:0]        byte_reg, byte_next;
    logic [23:0]       rgb_reg, rgb_next;
    logic [7:0]        tx_reg, tx_next;
    logic [7:0]        rx_reg, rx_next;
    logic [7:0]        b0_reg, b0_next;
    logic [1:0]        b1_reg, b1_next;
    logic [7:0]        b2_reg, b2_next;
    logic [1:0]        b3_reg, b3_next;
    logic              sclk_reg, sclk_next;
    logic              ss_n_reg, ss_n_next;
    logic              mosi_reg, mosi_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [9:0]        joy_x_reg, joy_x_next;
    logic [9:0]        joy_y_reg, joy_y_next;
    logic [1:0]        joy_btn_reg, joy_btn_next;

    logic [2:0]        byte_inc;
    logic [7:0]        next_tx_byte;

    // Transmit byte for a given packet position, using the latched colour.
    function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [23:0] rgb);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_BYTE;
            3'd1:    b = rgb[23:16];
            3'd2:    b = rgb[15:8];
            3'd3:    b = rgb[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign byte_inc     = 3'(byte_reg + 3'd1);
    assign next_tx_byte = tx_byte(byte_inc, rgb_reg);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        half_next    = half_reg;
        bit_next     = bit_reg;
        byte_next    = byte_reg;
        rgb_next     = rgb_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        b0_next      = b0_reg;
        b1_next      = b1_reg;
        b2_next      = b2_reg;
        b3_next      = b3_reg;
        sclk_next    = sclk_reg;
        ss_n_next    = ss_n_reg;
        mosi_next    = mosi_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        joy_x_next   = joy_x_reg;
        joy_y_next   = joy_y_reg;
        joy_btn_next = joy_btn_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETUP;
                    cnt_next   = SETUP_LOAD;
                    rgb_next   = rgb_color;
                    tx_next    = CMD_BYTE;
                    mosi_next  = CMD_BYTE[7];
                    byte_next  = 3'd0;
                    bit_next   = 3'd0;
                    half_next  = 1'b0;
                    sclk_next  = 1'b0;
                    ss_n_next  = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            ST_SETUP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SHIFT;
                    cnt_next   = HALF_LOAD;
                    half_next  = 1'b0;
                    bit_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_SHIFT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_ONE;
                end else if (!half_reg) begin
                    // Rising edge: the slave's bit is stable, capture it here.
                    sclk_next = 1'b1;
                    half_next = 1'b1;
                    cnt_next  = HALF_LOAD;
                    rx_next   = {rx_reg[6:0], miso};
                end else begin
                    sclk_next = 1'b0;
                    if (bit_reg == 3'd7) begin
                        // rx_reg already holds the full byte after the 8th rise.
                        case (byte_reg)
                            3'd0:    b0_next = rx_reg;
                            3'd1:    b1_next = rx_reg[1:0];
                            3'd2:    b2_next = rx_reg;
                            3'd3:    b3_next = rx_reg[1:0];
                            default: ;
                        endcase
                        if (byte_reg == 3'd4) begin
                            state_next = ST_TAIL;
                            cnt_next   = HALF_LOAD;
                            mosi_next  = 1'b0;
                        end else begin
                            state_next = ST_GAP;
                            cnt_next   = GAP_LOAD;
                            byte_next  = byte_inc;
                            tx_next    = next_tx_byte;
                            mosi_next  = next_tx_byte[7];
                        end
                    end else begin
                        bit_next  = 3'(bit_reg + 3'd1);
                        half_next = 1'b0;
                        cnt_next  = HALF_LOAD;
                        tx_next   = {tx_reg[6:0], 1'b0};
                        mosi_next = tx_reg[6];
                    end
                end
            end

            ST_GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SHIFT;
                    cnt_next   = HALF_LOAD;
                    half_next  = 1'b0;
                    bit_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_TAIL: begin
                // Final low half after the last bit, then release the slave.
                if (cnt_reg == '0) begin
                    state_next   = ST_HOLD;
                    ss_n_next    = 1'b1;
                    done_next    = 1'b1;
                    joy_x_next   = {b1_reg, b0_reg};
                    joy_y_next   = {b3_reg, b2_reg};
                    joy_btn_next = rx_reg[1:0];
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_HOLD: begin
                state_next = ST_REST;
                cnt_next   = REST_LOAD;
            end

            ST_REST: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                ss_n_next  = 1'b1;
                sclk_next  = 1'b0;
                mosi_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            half_reg    <= 1'b0;
            bit_reg     <= 3'd0;
            byte_reg    <= 3'd0;
            rgb_reg     <= 24'h0;
            tx_reg      <= 8'h0;
            rx_reg      <= 8'h0;
            b0_reg      <= 8'h0;
            b1_reg      <= 2'b0;
            b2_reg      <= 8'h0;
            b3_reg      <= 2'b0;
            sclk_reg    <= 1'b0;
            ss_n_reg    <= 1'b1;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            joy_x_reg   <= 10'h0;
            joy_y_reg   <= 10'h0;
            joy_btn_reg <= 2'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            half_reg    <= half_next;
            bit_reg     <= bit_next;
            byte_reg    <= byte_next;
            rgb_reg     <= rgb_next;
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            b0_reg      <= b0_next;
            b1_reg      <= b1_next;
            b2_reg      <= b2_next;
            b3_reg      <= b3_next;
            sclk_reg    <= sclk_next;
            ss_n_reg    <= ss_n_next;
            mosi_reg    <= mosi_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            joy_x_reg   <= joy_x_next;
            joy_y_reg   <= joy_y_next;
            joy_btn_reg <= joy_btn_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign ss_n    = ss_n_reg;
    assign sclk    = sclk_reg;
    assign mosi    = mosi_reg;
    assign joy_x   = joy_x_reg;
    assign joy_y   = joy_y_reg;
    assign joy_btn = joy_btn_reg;

endmodule

// File: tb/tb_jstk2_led_frame.sv
// Bench for jstk2_led_frame: directed frames with a PmodJSTK2 slave model.
// Stimulus pushes the expected frame into a queue; an SPI monitor collects
// what appears on the pins and checks it when ss_n rises.
module tb_jstk2_led_frame;

    localparam int CLK_DIV   = 6;
    localparam int SS_SETUP  = 180;
    localparam int BYTE_GAP  = 120;
    localparam int FRAME_GAP = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [23:0] rgb_color = 24'h0;
    logic        miso = 1'b0;
    logic        busy, done, ss_n, sclk, mosi;
    logic [9:0]  joy_x, joy_y;
    logic [1:0]  joy_btn;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [39:0] slave_reply = 40'h0;

    typedef struct {
        logic [39:0] tx;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [1:0]  btn;
    } exp_t;

    exp_t expq[$];

    jstk2_led_frame #(
        .CLK_DIV   (CLK_DIV),
        .SS_SETUP  (SS_SETUP),
        .BYTE_GAP  (BYTE_GAP),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rgb_color (rgb_color),
        .busy      (busy),
        .done      (done),
        .ss_n      (ss_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .joy_x     (joy_x),
        .joy_y     (joy_y),
        .joy_btn   (joy_btn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss_n"},    ss_n,    1);
        check({tag, "_sclk"},    sclk,    0);
        check({tag, "_mosi"},    mosi,    0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_joy_x"},   joy_x,   0);
        check({tag, "_joy_y"},   joy_y,   0);
        check({tag, "_joy_btn"}, joy_btn, 0);
    endtask

    // Slave: shifts its reply out MSB first, changing miso after sclk falls.
    initial begin
        int  sl_idx;
        logic prev_sclk_s;
        sl_idx = 0;
        prev_sclk_s = 1'b0;
        forever begin
            @(negedge clk);
            if (ss_n !== 1'b0) sl_idx = 0;
            else if (prev_sclk_s && !sclk) sl_idx++;
            miso = (sl_idx < 40) ? slave_reply[39 - sl_idx] : 1'b0;
            prev_sclk_s = sclk;
        end
    end

    // Monitor: reconstructs each frame from the pins and checks it against the queue.
    initial begin
        exp_t e;
        logic prev_sclk, prev_ss, prev_busy, prev_mosi;
        logic [39:0] rx_bits;
        int cyc, rise_cnt, ss_fall_cyc, last_fall_cyc, setup_meas;
        int gap_bad, mode0_bad, ss_rise_cyc;
        bit in_frame, wait_busy, frame_end;
        prev_sclk = 1'b0; prev_ss = 1'b1; prev_busy = 1'b0; prev_mosi = 1'b0;
        rx_bits = '0; cyc = 0; rise_cnt = 0; ss_fall_cyc = 0; last_fall_cyc = 0;
        setup_meas = -1; gap_bad = 0; mode0_bad = 0; ss_rise_cyc = 0;
        in_frame = 0; wait_busy = 0;
        forever begin
            @(negedge clk);
            cyc++;
            frame_end = 0;
            if (rst) begin
                in_frame = 0;
                wait_busy = 0;
            end else begin
                if (prev_ss && !ss_n) begin
                    in_frame = 1; rise_cnt = 0; ss_fall_cyc = cyc;
                    gap_bad = 0; mode0_bad = 0; setup_meas = -1; rx_bits = '0;
                end
                if (in_frame && !ss_n) begin
                    if (!prev_sclk && sclk) begin
                        if (rise_cnt == 0)
                            setup_meas = cyc - ss_fall_cyc;
                        // byte gap plus the next bit's low half
                        else if (rise_cnt % 8 == 0 && (cyc - last_fall_cyc) != BYTE_GAP + CLK_DIV)
                            gap_bad++;
                        rx_bits = {rx_bits[38:0], mosi};
                        rise_cnt++;
                    end
                    if (prev_sclk && !sclk) last_fall_cyc = cyc;
                    if (prev_sclk && sclk && mosi !== prev_mosi) mode0_bad++;
                end
                if (!prev_ss && ss_n && in_frame) begin
                    frame_end = 1;
                    in_frame = 0;
                    $display("frame tx=%010h rises=%0d setup=%0d done=%0b joy_x=%03h joy_y=%03h joy_btn=%0b",
                             rx_bits, rise_cnt, setup_meas, done, joy_x, joy_y, joy_btn);
                    if (expq.size() == 0) begin
                        check("frame_expected", 0, 1);
                    end else begin
                        e = expq.pop_front();
                        check("mosi_bytes",    rx_bits,   e.tx);
                        check("sclk_rises",    rise_cnt,  40);
                        check("setup_cycles",  setup_meas, SS_SETUP);
                        check("byte_gap_bad",  gap_bad,   0);
                        check("mode0_bad",     mode0_bad, 0);
                        check("done_at_end",   done,      1);
                        check("joy_x",         joy_x,     e.x);
                        check("joy_y",         joy_y,     e.y);
                        check("joy_btn",       joy_btn,   e.btn);
                    end
                    ss_rise_cyc = cyc;
                    wait_busy = 1;
                end
                if (done) begin
                    done_cnt++;
                    check("done_only_at_frame_end", frame_end, 1);
                end
                if (wait_busy && prev_busy && !busy) begin
                    check("busy_after_ss_rise", cyc - ss_rise_cyc, FRAME_GAP);
                    wait_busy = 0;
                end
            end
            prev_sclk = sclk; prev_ss = ss_n; prev_busy = busy; prev_mosi = mosi;
        end
    end

    task automatic issue(input logic [23:0] rgb, input logic [39:0] reply, input logic [39:0] tx,
                         input logic [9:0] x, input logic [9:0] y, input logic [1:0] btn);
        exp_t e;
        @(negedge clk);
        rgb_color = rgb;
        slave_reply = reply;
        e.tx = tx; e.x = x; e.y = y; e.btn = btn;
        expq.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Frame content, decode and timing.
        issue(24'h7F0000, 40'h34_02_FF_03_03, 40'h84_7F_00_00_00, 10'h234, 10'h3FF, 2'b11);
        wait_idle("f1_idle", 4000);

        // Mid-frame start and colour change must not disturb this frame.
        issue(24'h7F0000, 40'h55_FD_AA_02_FE, 40'h84_7F_00_00_00, 10'h155, 10'h2AA, 2'b10);
        repeat (600) @(negedge clk);
        rgb_color = 24'h00007F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("f2_idle", 4000);
        repeat (20) @(negedge clk);
        check("no_queued_frame_busy", busy, 0);
        check("no_queued_frame_ss_n", ss_n, 1);

        // New colour is used by the next accepted start.
        issue(24'h00007F, 40'h0F_00_F0_01_02, 40'h84_00_00_7F_00, 10'h00F, 10'h1F0, 2'b10);
        wait_idle("f3_idle", 4000);

        // Abort during byte 2.
        @(negedge clk);
        rgb_color = 24'h123456;
        slave_reply = 40'hFF_FF_FF_FF_FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (650) @(posedge clk);
        check("abort_was_busy", busy, 1);
        #3 rst = 1'b1;
        #1 check_reset_outputs("abort");
        dc = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_joy_x", joy_x, 0);
        check("abort_joy_y", joy_y, 0);
        check("abort_joy_btn", joy_btn, 0);

        // Clean frame after abort.
        issue(24'h0A0B0C, 40'h01_01_02_02_01, 40'h84_0A_0B_0C_00, 10'h101, 10'h202, 2'b01);
        wait_idle("f5_idle", 4000);

        repeat (10) @(negedge clk);
        check("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
